// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one uart_tx write port among N_CH producers.
// A channel holds the port until its last beat, or until it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_CH       = 4,
  parameter int BYTE_WIDTH = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_CH-1:0]                       i_req,
  output logic [N_CH-1:0]                       o_gnt,
  input  logic [N_CH*BYTE_WIDTH*8-1:0]          i_data,
  input  logic [N_CH-1:0]                       i_last,
  output logic                                  o_wreq,
  input  logic                                  i_wgnt,
  output logic [BYTE_WIDTH*8-1:0]               o_wdata,
  output logic                                  o_busy,
  output logic [((N_CH>1)?$clog2(N_CH):1)-1:0]  o_owner,
  output logic                                  o_abort
);
  localparam int W  = BYTE_WIDTH*8;
  localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  // Abort fires on the stall cycle that would bring the count to TIMEOUT.
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [CW-1:0]   stall_cnt;
  logic [OW-1:0]   pick;
  logic [OW-1:0]   idx;
  logic [OW-1:0]   owner_inc;
  logic            found;
  logic            owner_req;
  logic            owner_last;
  logic [W-1:0]    lane_data [N_CH];

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_lane
      assign lane_data[c] = i_data[c*W +: W];
      assign o_gnt[c]     = (state == LOCK) && (o_owner == OW'(c)) && i_wgnt;
    end
  endgenerate

  assign owner_req  = i_req[o_owner];
  assign owner_last = i_last[o_owner];
  assign o_wreq     = (state == LOCK) && owner_req;
  assign o_wdata    = lane_data[o_owner];
  assign owner_inc  = (o_owner == OW'(N_CH-1)) ? '0 : o_owner + 1'b1;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = OW'((int'(rr_ptr) + i) % N_CH);
      if (!found && i_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      o_owner   <= '0;
      o_busy    <= 1'b0;
      o_abort   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= LOCK;
            o_owner   <= pick;
            o_busy    <= 1'b1;
            stall_cnt <= '0;
          end
        end
        LOCK: begin
          if (o_wreq && i_wgnt && owner_last) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            rr_ptr    <= owner_inc;
            stall_cnt <= '0;
          end else if (owner_req) begin
            stall_cnt <= '0;
          end else if (TIMEOUT > 0) begin
            if (stall_cnt >= LIM) begin
              state     <= IDLE;
              o_busy    <= 1'b0;
              o_abort   <= 1'b1;
              rr_ptr    <= owner_inc;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut uses TIMEOUT=16, dut_b (same stimulus) TIMEOUT=1024.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_req, i_last;
  logic [N*8-1:0] i_data;
  logic         i_wgnt;
  logic         req_a [N];
  logic         last_a [N];
  logic [7:0]   lane [N];

  logic [N-1:0] o_gnt, gnt_b;
  logic         o_wreq, wreq_b, o_busy, busy_b, o_abort, abort_b;
  logic [7:0]   o_wdata, wdata_b;
  logic [1:0]   o_owner, owner_b;

  int checks = 0;
  int errors = 0;

  assign i_req  = {req_a[3], req_a[2], req_a[1], req_a[0]};
  assign i_last = {last_a[3], last_a[2], last_a[1], last_a[0]};
  assign i_data = {lane[3], lane[2], lane[1], lane[0]};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_CH(N), .BYTE_WIDTH(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_gnt(o_gnt), .i_data(i_data),
    .i_last(i_last), .o_wreq(o_wreq), .i_wgnt(i_wgnt), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_owner(o_owner), .o_abort(o_abort));

  uart_tx_arbiter #(.N_CH(N), .BYTE_WIDTH(1), .TIMEOUT(1024)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_gnt(gnt_b), .i_data(i_data),
    .i_last(i_last), .o_wreq(wreq_b), .i_wgnt(i_wgnt), .o_wdata(wdata_b),
    .o_busy(busy_b), .o_owner(owner_b), .o_abort(abort_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    for (int c = 0; c < N; c++) begin
      req_a[c]  = 1'b0;
      last_a[c] = 1'b0;
      lane[c]   = 8'h00;
    end
    i_wgnt = 1'b0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (o_busy !== 1'b0 || o_abort !== 1'b0 || o_wreq !== 1'b0 || o_owner !== 2'd0 || o_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b abort=%b wreq=%b owner=%0d gnt=%b, required 0 0 0 0 0000",
               o_busy, o_abort, o_wreq, o_owner, o_gnt);
    end
    checks++;
    if (busy_b !== 1'b0 || owner_b !== 2'd0 || abort_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_b: busy=%b owner=%0d abort=%b, required 0 0 0", busy_b, owner_b, abort_b);
    end
    req_a[3] = 1'b1; lane[3] = 8'h77; i_wgnt = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b1 || o_owner !== 2'd3 || o_gnt !== 4'b1000 || o_wreq !== 1'b1) begin
      errors++;
      $display("FAIL reset_prelock: busy=%b owner=%0d gnt=%b wreq=%b, required 1 3 1000 1",
               o_busy, o_owner, o_gnt, o_wreq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_wreq !== 1'b0 || o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: wreq=%b gnt=%b busy=%b owner=%0d, required 0 0000 0 0",
               o_wreq, o_gnt, o_busy, o_owner);
    end
    #1 rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single;
    apply_reset();
    i_wgnt = 1'b1;
    req_a[2] = 1'b1; lane[2] = 8'h41;
    #1;
    checks++;
    if (o_wreq !== 1'b0 || o_busy !== 1'b0 || o_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_bubble: wreq=%b busy=%b gnt=%b, required 0 0 0000", o_wreq, o_busy, o_gnt);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      lane[2]   = 8'h41 + 8'(k);
      last_a[2] = (k == 2);
      #1;
      checks++;
      if (o_wreq !== 1'b1 || o_gnt !== 4'b0100 || o_wdata !== 8'h41 + 8'(k)) begin
        errors++;
        $display("FAIL single_beat%0d: wreq=%b gnt=%b wdata=%h, required 1 0100 %h",
                 k, o_wreq, o_gnt, o_wdata, 8'h41 + 8'(k));
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_round_robin;
    int beat [N];
    logic [7:0] got [$];
    logic [N-1:0] g;
    logic [7:0] exp_b;
    apply_reset();
    i_wgnt = 1'b1;
    for (int c = 0; c < N; c++) beat[c] = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      for (int c = 0; c < N; c++) begin
        req_a[c]  = 1'b1;
        lane[c]   = 8'(c*16 + beat[c]);
        last_a[c] = (beat[c] == 1);
      end
      #1;
      if (o_wreq && i_wgnt) got.push_back(o_wdata);
      g = o_gnt;
      tick();
      for (int c = 0; c < N; c++) if (g[2'(c)]) beat[c] = 1 - beat[c];
    end
    clear_inputs();
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL rr_count: got %0d bytes, required 16", got.size());
    end
    for (int m = 0; m < 16; m++) begin
      exp_b = 8'(((m/2) % 4)*16 + (m % 2));
      if (m < got.size()) begin
        checks++;
        if (got[m] !== exp_b) begin
          errors++;
          $display("FAIL rr_byte%0d: got %h, required %h", m, got[m], exp_b);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int ab = 0, abb = 0, bad = 0;
    apply_reset();
    req_a[1] = 1'b1; lane[1] = 8'h55; last_a[1] = 1'b1; i_wgnt = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (o_abort !== 1'b0) ab++;
      if (abort_b !== 1'b0) abb++;
      if (o_busy !== 1'b1 || o_owner !== 2'd1 || o_gnt !== 4'b0000) bad++;
    end
    checks++;
    if (ab != 0) begin errors++; $display("FAIL bp_abort_t16: %0d abort cycles, required 0", ab); end
    checks++;
    if (abb != 0) begin errors++; $display("FAIL bp_abort_t1024: %0d abort cycles, required 0", abb); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d cycles lost lock or granted, required 0", bad); end
    i_wgnt = 1'b1;
    #1;
    checks++;
    if (o_wreq !== 1'b1 || o_gnt !== 4'b0010 || o_wdata !== 8'h55 || gnt_b !== 4'b0010) begin
      errors++;
      $display("FAIL bp_deliver: wreq=%b gnt=%b wdata=%h gnt_b=%b, required 1 0010 55 0010",
               o_wreq, o_gnt, o_wdata, gnt_b);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (o_busy !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: busy=%b busy_b=%b, required 0 0", o_busy, busy_b);
    end
  endtask

  task automatic test_timeout;
    apply_reset();
    i_wgnt = 1'b1;
    req_a[0] = 1'b1; lane[0] = 8'hAA;
    req_a[1] = 1'b1; lane[1] = 8'hBB; last_a[1] = 1'b1;
    tick();
    checks++;
    if (o_gnt !== 4'b0001 || o_wdata !== 8'hAA || o_owner !== 2'd0) begin
      errors++;
      $display("FAIL to_lock0: gnt=%b wdata=%h owner=%0d, required 0001 aa 0", o_gnt, o_wdata, o_owner);
    end
    tick();
    req_a[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (o_abort !== (k == 16) || o_gnt[1] !== 1'b0) begin
        errors++;
        $display("FAIL to_cycle%0d: abort=%b gnt1=%b, required %b 0", k, o_abort, o_gnt[1], (k == 16));
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL to_unlock: busy=%b, required 0", o_busy); end
    tick();
    checks++;
    if (o_busy !== 1'b1 || o_owner !== 2'd1 || o_abort !== 1'b0 || o_gnt !== 4'b0010 || o_wdata !== 8'hBB) begin
      errors++;
      $display("FAIL to_next_ch1: busy=%b owner=%0d abort=%b gnt=%b wdata=%h, required 1 1 0 0010 bb",
               o_busy, o_owner, o_abort, o_gnt, o_wdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_end_to_end;
    logic [7:0] exp_s [6] = '{8'h41, 8'h42, 8'h0a, 8'h43, 8'h44, 8'h0a};
    logic [7:0] got [$];
    logic [N-1:0] g;
    int p0 = 0, p2 = 0;
    apply_reset();
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      req_a[0]  = (p0 < 3);
      lane[0]   = (p0 < 3) ? exp_s[p0] : 8'h00;
      last_a[0] = (p0 == 2);
      req_a[2]  = (p2 < 3);
      lane[2]   = (p2 < 3) ? exp_s[3+p2] : 8'h00;
      last_a[2] = (p2 == 2);
      i_wgnt    = (cyc % 3 != 1);
      #1;
      if (o_wreq && i_wgnt) got.push_back(o_wdata);
      g = o_gnt;
      tick();
      if (g[0] && req_a[0]) p0++;
      if (g[2] && req_a[2]) p2++;
    end
    clear_inputs();
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL e2e_count: got %0d bytes within 60 cycles, required 6", got.size());
    end
    for (int m = 0; m < 6; m++) begin
      if (m < got.size()) begin
        checks++;
        if (got[m] !== exp_s[m]) begin
          errors++;
          $display("FAIL e2e_byte%0d: got %h, required %h", m, got[m], exp_s[m]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_end_to_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
